// File: rtl/noc_wrr_if.sv
// Bundle between the router input buffers, the WRR scheduler and the output link.
// Handshake: a flit moves on a cycle where valid and ready are both high; valid, once up, holds its flit until accepted.
interface noc_wrr_if #(
  parameter int FLIT_WIDTH   = 32,
  parameter int CHANNELS     = 7,
  parameter int WEIGHT_WIDTH = 4
);
  logic [CHANNELS-1:0][FLIT_WIDTH-1:0]   in_flit;
  logic [CHANNELS-1:0]                   in_last;
  logic [CHANNELS-1:0]                   in_valid;
  logic [CHANNELS-1:0]                   in_ready;
  logic [FLIT_WIDTH-1:0]                 out_flit;
  logic                                  out_last;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [CHANNELS-1:0][WEIGHT_WIDTH-1:0] cfg_weight;
  logic [CHANNELS-1:0]                   grant;

  modport master (
    output in_flit, in_last, in_valid, out_ready, cfg_weight,
    input  in_ready, out_flit, out_last, out_valid, grant
  );

  modport slave (
    input  in_flit, in_last, in_valid, out_ready, cfg_weight,
    output in_ready, out_flit, out_last, out_valid, grant
  );
endinterface

// File: rtl/noc_wrr_scheduler.sv
// Weighted round-robin packet scheduler and output mux for one NoC output port.
// A channel wins in IDLE and keeps the link in ROUTE until its last flit transfers.
module noc_wrr_scheduler #(
  parameter int FLIT_WIDTH   = 32,
  parameter int CHANNELS     = 7,
  parameter int WEIGHT_WIDTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  noc_wrr_if.slave bus,
  output logic     o_dbg_state
);
  localparam int IDX_W = $clog2(CHANNELS);

  typedef enum logic {S_IDLE = 1'b0, S_ROUTE = 1'b1} state_t;

  state_t                  r_state;
  logic [IDX_W-1:0]        r_owner;
  logic [IDX_W-1:0]        r_ptr;
  logic [CHANNELS-1:0]     r_grant;
  logic [WEIGHT_WIDTH-1:0] r_credit [CHANNELS];

  logic [CHANNELS-1:0]     w_eligible;
  logic                    w_found;
  logic [IDX_W-1:0]        w_pick;
  int                      w_scan;
  logic                    w_route;
  logic                    w_owner_valid;
  logic                    w_xfer;

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_eligible[c] = bus.in_valid[c] && (r_credit[c] != '0);
    end
  end

  // Scan starts just after the last served channel, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_scan  = 0;
    for (int k = 1; k <= CHANNELS; k++) begin
      w_scan = int'(r_ptr) + k;
      if (w_scan >= CHANNELS) w_scan = w_scan - CHANNELS;
      if (!w_found && w_eligible[IDX_W'(w_scan)]) begin
        w_found = 1'b1;
        w_pick  = IDX_W'(w_scan);
      end
    end
  end

  assign w_route       = (r_state == S_ROUTE);
  assign w_owner_valid = w_route && bus.in_valid[r_owner];
  assign w_xfer        = w_owner_valid && bus.out_ready;

  assign bus.out_valid = w_owner_valid;
  assign bus.in_ready  = w_xfer ? r_grant : '0;
  assign bus.out_flit  = w_route ? bus.in_flit[r_owner] : '0;
  assign bus.out_last  = w_route && bus.in_last[r_owner];
  assign bus.grant     = r_grant;
  assign o_dbg_state   = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_ptr   <= IDX_W'(CHANNELS - 1);
      r_grant <= '0;
      for (int c = 0; c < CHANNELS; c++) r_credit[c] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_owner <= w_pick;
            r_grant <= CHANNELS'(1) << w_pick;
            r_state <= S_ROUTE;
          end else if (|bus.in_valid) begin
            // Round exhausted for every requester: refill, a zero weight counts as one.
            for (int c = 0; c < CHANNELS; c++) begin
              r_credit[c] <= (bus.cfg_weight[c] == '0) ? WEIGHT_WIDTH'(1) : bus.cfg_weight[c];
            end
          end
        end
        S_ROUTE: begin
          if (w_xfer && bus.in_last[r_owner]) begin
            r_credit[r_owner] <= r_credit[r_owner] - WEIGHT_WIDTH'(1);
            r_ptr             <= r_owner;
            r_grant           <= '0;
            r_state           <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_noc_wrr_scheduler.sv
// Directed bench for noc_wrr_scheduler: inputs change 1ns after posedge, outputs are sampled on negedge.
module tb_noc_wrr_scheduler;
  localparam int FW = 32;
  localparam int CH = 7;
  localparam int WW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dbg_state;
  int   n_tests = 0;
  int   n_fail = 0;

  noc_wrr_if #(.FLIT_WIDTH(FW), .CHANNELS(CH), .WEIGHT_WIDTH(WW)) bus ();

  noc_wrr_scheduler #(.FLIT_WIDTH(FW), .CHANNELS(CH), .WEIGHT_WIDTH(WW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.in_flit   = '0;
    bus.in_last   = '0;
    bus.in_valid  = '0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < CH; c++) bus.cfg_weight[c] = WW'(1);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    bus.in_valid  = '1;
    bus.in_last   = '1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < CH; c++) bus.in_flit[c] = FW'(32'h100 + c);
    @(negedge clk);
    n_tests++; if (bus.in_ready !== 7'h00) begin n_fail++; $display("FAIL rst_in_ready: got %0h expected 0", bus.in_ready); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b expected 0", bus.out_valid); end
    n_tests++; if (bus.grant !== 7'h00) begin n_fail++; $display("FAIL rst_grant: got %0h expected 0", bus.grant); end
    n_tests++; if (bus.out_flit !== 32'h0) begin n_fail++; $display("FAIL rst_out_flit: got %0h expected 0", bus.out_flit); end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.grant !== 7'h00) begin n_fail++; $display("FAIL rst_bubble_grant: got %0h expected 0", bus.grant); end
    next_cycle();
    @(negedge clk);
    n_tests++; if (bus.grant !== 7'h00) begin n_fail++; $display("FAIL rst_arb_grant: got %0h expected 0", bus.grant); end
    next_cycle();
    @(negedge clk);
    n_tests++; if (bus.grant !== 7'h01) begin n_fail++; $display("FAIL rst_first_grant: got %0h expected 1", bus.grant); end
    n_tests++; if (bus.out_flit !== 32'h100) begin n_fail++; $display("FAIL rst_first_flit: got %0h expected 100", bus.out_flit); end
    n_tests++; if (bus.in_ready !== 7'h01) begin n_fail++; $display("FAIL rst_first_ready: got %0h expected 1", bus.in_ready); end
  endtask

  task automatic test_weighted_round();
    int exp_g [15] = '{0, 0, 1, 0, 2, 0, 1, 0, 0, 2, 0, 1, 0, 1, 0};
    int n0 = 0;
    int n1 = 0;
    apply_reset();
    bus.cfg_weight[0] = WW'(2);
    bus.in_valid      = 7'b0000011;
    bus.in_last       = 7'b0000011;
    bus.in_flit[0]    = 32'hA0;
    bus.in_flit[1]    = 32'hA1;
    bus.out_ready     = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      n_tests++;
      if (bus.grant !== CH'(exp_g[i])) begin
        n_fail++; $display("FAIL wrr_grant[%0d]: got %0h expected %0h", i, bus.grant, exp_g[i]);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (bus.grant[0]) n0++;
        if (bus.grant[1]) n1++;
      end
      next_cycle();
    end
    n_tests++; if (n0 !== 4) begin n_fail++; $display("FAIL wrr_ch0_pkts: got %0d expected 4", n0); end
    n_tests++; if (n1 !== 2) begin n_fail++; $display("FAIL wrr_ch1_pkts: got %0d expected 2", n1); end
  endtask

  task automatic test_no_interleave();
    int idx = 0;
    int last_cyc = -10;
    int first3 = -1;
    bit ch3_done = 1'b0;
    apply_reset();
    bus.in_flit[3] = 32'h300;
    bus.in_last[3] = 1'b1;
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 60 && !ch3_done; cyc++) begin
      bus.out_ready   = (cyc % 2 == 0);
      bus.in_valid[2] = (idx < 4);
      bus.in_flit[2]  = FW'(32'h200 + idx);
      bus.in_last[2]  = (idx == 3);
      bus.in_valid[3] = (idx >= 1);
      @(negedge clk);
      if (idx < 4 && bus.grant !== 7'h00) begin
        n_tests++;
        if (bus.grant !== 7'h04) begin n_fail++; $display("FAIL nil_owner[%0d]: got %0h expected 4", cyc, bus.grant); end
      end
      if (cyc == last_cyc + 1) begin
        n_tests++;
        if (bus.grant !== 7'h00) begin n_fail++; $display("FAIL nil_idle_gap: got %0h expected 0", bus.grant); end
      end
      if (bus.grant === 7'h08 && first3 < 0) first3 = cyc;
      if (bus.out_valid && bus.out_ready) begin
        if (idx < 4) begin
          n_tests++;
          if (bus.out_flit !== FW'(32'h200 + idx)) begin
            n_fail++; $display("FAIL nil_flit[%0d]: got %0h expected %0h", idx, bus.out_flit, 32'h200 + idx);
          end
          n_tests++;
          if (bus.out_last !== (idx == 3)) begin n_fail++; $display("FAIL nil_last[%0d]: got %0b expected %0b", idx, bus.out_last, idx == 3); end
          idx++;
          if (idx == 4) last_cyc = cyc;
        end else if (bus.grant === 7'h08) begin
          ch3_done = 1'b1;
        end
      end
      next_cycle();
    end
    n_tests++; if (idx !== 4) begin n_fail++; $display("FAIL nil_ch2_flits: got %0d expected 4", idx); end
    n_tests++; if (!ch3_done) begin n_fail++; $display("FAIL nil_ch3_timeout: got 0 expected 1"); end
    n_tests++; if (first3 !== last_cyc + 2) begin n_fail++; $display("FAIL nil_ch3_grant_cyc: got %0d expected %0d", first3, last_cyc + 2); end
  endtask

  task automatic test_weight_zero();
    int exp_g [12] = '{0, 0, 16, 0, 0, 16, 0, 0, 16, 0, 0, 0};
    int sent = 0;
    apply_reset();
    bus.cfg_weight[4] = '0;
    bus.in_last[4]    = 1'b1;
    bus.out_ready     = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.in_valid[4] = (sent < 3);
      bus.in_flit[4]  = FW'(32'h400 + sent);
      @(negedge clk);
      n_tests++;
      if (bus.grant !== CH'(exp_g[i])) begin n_fail++; $display("FAIL wz_grant[%0d]: got %0h expected %0h", i, bus.grant, exp_g[i]); end
      if (bus.out_valid && bus.out_ready) begin
        n_tests++;
        if (bus.out_flit !== FW'(32'h400 + sent)) begin n_fail++; $display("FAIL wz_flit[%0d]: got %0h expected %0h", sent, bus.out_flit, 32'h400 + sent); end
        sent++;
      end
      next_cycle();
    end
    n_tests++; if (sent !== 3) begin n_fail++; $display("FAIL wz_packets: got %0d expected 3", sent); end
  endtask

  task automatic test_source_stall();
    int exp_g [10] = '{0, 0, 32, 32, 32, 32, 32, 32, 0, 64};
    bit exp_v [10] = '{0, 0, 1, 0, 0, 0, 1, 1, 0, 1};
    int idx = 0;
    apply_reset();
    bus.in_valid[6] = 1'b1;
    bus.in_last[6]  = 1'b1;
    bus.in_flit[6]  = 32'h600;
    bus.out_ready   = 1'b1;
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      bus.in_valid[5] = (idx < 3) && !(cyc >= 3 && cyc <= 5);
      bus.in_flit[5]  = FW'(32'h500 + idx);
      bus.in_last[5]  = (idx == 2);
      @(negedge clk);
      n_tests++;
      if (bus.grant !== CH'(exp_g[cyc])) begin n_fail++; $display("FAIL stall_grant[%0d]: got %0h expected %0h", cyc, bus.grant, exp_g[cyc]); end
      n_tests++;
      if (bus.out_valid !== exp_v[cyc]) begin n_fail++; $display("FAIL stall_valid[%0d]: got %0b expected %0b", cyc, bus.out_valid, exp_v[cyc]); end
      if (cyc < 9) begin
        n_tests++;
        if (bus.in_ready[6] !== 1'b0) begin n_fail++; $display("FAIL stall_ch6_ready[%0d]: got 1 expected 0", cyc); end
      end
      if (bus.out_valid && bus.out_ready && bus.grant[5]) begin
        n_tests++;
        if (bus.out_flit !== FW'(32'h500 + idx)) begin n_fail++; $display("FAIL stall_flit[%0d]: got %0h expected %0h", idx, bus.out_flit, 32'h500 + idx); end
        idx++;
      end
      next_cycle();
    end
    n_tests++; if (idx !== 3) begin n_fail++; $display("FAIL stall_ch5_flits: got %0d expected 3", idx); end
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    bus.in_valid[1] = 1'b1;
    bus.out_ready   = 1'b1;
    bus.in_flit[1]  = 32'h110;
    rst_n = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_tests++; if (bus.out_flit !== 32'h110) begin n_fail++; $display("FAIL rmp_flit1: got %0h expected 110", bus.out_flit); end
    next_cycle();
    bus.in_flit[1] = 32'h111;
    @(negedge clk);
    n_tests++; if (bus.grant !== 7'h02) begin n_fail++; $display("FAIL rmp_grant_flit2: got %0h expected 2", bus.grant); end
    n_tests++; if (bus.out_flit !== 32'h111) begin n_fail++; $display("FAIL rmp_flit2: got %0h expected 111", bus.out_flit); end
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmp_async_valid: got %0b expected 0", bus.out_valid); end
    n_tests++; if (bus.grant !== 7'h00) begin n_fail++; $display("FAIL rmp_async_grant: got %0h expected 0", bus.grant); end
    n_tests++; if (bus.in_ready !== 7'h00) begin n_fail++; $display("FAIL rmp_async_ready: got %0h expected 0", bus.in_ready); end
    n_tests++; if (bus.out_flit !== 32'h0) begin n_fail++; $display("FAIL rmp_async_flit: got %0h expected 0", bus.out_flit); end
    next_cycle();
    bus.in_flit[1] = 32'h110;
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.grant !== 7'h00) begin n_fail++; $display("FAIL rmp_bubble: got %0h expected 0", bus.grant); end
    next_cycle();
    @(negedge clk);
    n_tests++; if (bus.grant !== 7'h00) begin n_fail++; $display("FAIL rmp_arb: got %0h expected 0", bus.grant); end
    next_cycle();
    @(negedge clk);
    n_tests++; if (bus.grant !== 7'h02) begin n_fail++; $display("FAIL rmp_regrant: got %0h expected 2", bus.grant); end
    n_tests++; if (bus.out_flit !== 32'h110) begin n_fail++; $display("FAIL rmp_restart_flit: got %0h expected 110", bus.out_flit); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_weighted_round();
    test_no_interleave();
    test_weight_zero();
    test_source_stall();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
